// File: rtl/bsg_fifo_rr_enq_scheduler.sv
// Round-robin enqueue scheduler sharing one small FIFO between several
// valid/ready producers. Each accepted beat is tagged with its source index,
// per-source FIFO occupancy is capped, and a multi-beat packet keeps the
// grant until its last beat. Occupancy credit returns via the dequeue tag.
module bsg_fifo_rr_enq_scheduler #(
    parameter  int unsigned num_req_p     = 4,
    parameter  int unsigned width_p       = 32,
    parameter  int unsigned max_per_src_p = 2,
    localparam int unsigned tag_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int unsigned cnt_width_lp  = (max_per_src_p > 0) ? $clog2(max_per_src_p + 1) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p-1:0]              v_i,
    input  logic [num_req_p-1:0]              last_i,
    input  logic [num_req_p*width_p-1:0]      data_i,
    output logic [num_req_p-1:0]              ready_o,
    output logic                              fifo_v_o,
    output logic [tag_width_lp+width_p-1:0]   fifo_data_o,
    input  logic                              fifo_ready_i,
    input  logic                              deq_v_i,
    input  logic [tag_width_lp-1:0]           deq_tag_i
);

    logic [tag_width_lp-1:0] last_r;
    logic                    lock_r;
    logic [tag_width_lp-1:0] lock_tag_r;
    logic [cnt_width_lp-1:0] cnt_r [num_req_p];

    logic [num_req_p-1:0]    elig;
    logic                    grant_v;
    logic [tag_width_lp-1:0] grant;
    logic                    xfer;

    // A source may send only while it holds fewer than the quota in the FIFO
    always_comb begin
        for (int unsigned i = 0; i < num_req_p; i++) begin
            elig[i] = v_i[i] && (32'(cnt_r[i]) < max_per_src_p);
        end
    end

    // Grant selection: locked source only, else rotating priority after last_r
    always_comb begin
        logic [tag_width_lp-1:0] cand;
        grant_v = 1'b0;
        grant   = '0;
        cand    = '0;
        if (reset_i) begin
            grant_v = 1'b0;
        end else if (lock_r) begin
            if (elig[lock_tag_r]) begin
                grant_v = 1'b1;
                grant   = lock_tag_r;
            end
        end else begin
            // Scan farthest offset first so the nearest eligible source wins
            for (int unsigned k = num_req_p; k >= 1; k--) begin
                cand = tag_width_lp'((32'(last_r) + k) % num_req_p);
                if (elig[cand]) begin
                    grant_v = 1'b1;
                    grant   = cand;
                end
            end
        end
    end

    // Enqueue-side outputs are a direct combinational pass-through of the grant
    always_comb begin
        ready_o = '0;
        if (grant_v && fifo_ready_i) begin
            ready_o[grant] = 1'b1;
        end
        fifo_v_o    = grant_v;
        fifo_data_o = {grant, data_i[32'(grant)*width_p +: width_p]};
    end

    assign xfer = grant_v && fifo_ready_i;

    // Round-robin pointer and packet lock
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_r     <= tag_width_lp'(num_req_p - 1);
            lock_r     <= 1'b0;
            lock_tag_r <= '0;
        end else if (xfer) begin
            last_r <= grant;
            if (last_i[grant]) begin
                lock_r <= 1'b0;
            end else begin
                lock_r     <= 1'b1;
                lock_tag_r <= grant;
            end
        end
    end

    // Per-source occupancy: inc on enqueue, dec on dequeue, never wraps
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < num_req_p; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < num_req_p; i++) begin
                logic inc;
                logic dec;
                inc = xfer && (grant == tag_width_lp'(i));
                dec = deq_v_i && (deq_tag_i == tag_width_lp'(i)) && (cnt_r[i] != '0);
                if (inc && !dec) begin
                    cnt_r[i] <= cnt_r[i] + cnt_width_lp'(1);
                end else if (dec && !inc) begin
                    cnt_r[i] <= cnt_r[i] - cnt_width_lp'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Flag consumer protocol errors on the credit-return path
    always_ff @(posedge clk_i) begin
        if (!reset_i && deq_v_i) begin
            if (32'(deq_tag_i) >= num_req_p) begin
                $display("%m error: deque tag out of range %d", deq_tag_i);
            end else if (cnt_r[deq_tag_i] == '0) begin
                $display("%m error: deque underflow tag %d", deq_tag_i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_fifo_rr_enq_scheduler.sv
// Directed bench for the round-robin enqueue scheduler.
module tb_bsg_fifo_rr_enq_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned TW = 2;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [N-1:0]     v_i;
    logic [N-1:0]     last_i;
    logic [N*W-1:0]   data_i;
    logic [N-1:0]     ready_o;
    logic             fifo_v_o;
    logic [TW+W-1:0]  fifo_data_o;
    logic             fifo_ready_i;
    logic             deq_v_i;
    logic [TW-1:0]    deq_tag_i;

    int n_tests = 0;
    int n_fail  = 0;

    bsg_fifo_rr_enq_scheduler #(
        .num_req_p     (N),
        .width_p       (W),
        .max_per_src_p (2)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .last_i       (last_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .fifo_v_o     (fifo_v_o),
        .fifo_data_o  (fifo_data_o),
        .fifo_ready_i (fifo_ready_i),
        .deq_v_i      (deq_v_i),
        .deq_tag_i    (deq_tag_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [W-1:0] slot_data(input int unsigned i);
        return 32'hC0DE_0000 + i;
    endfunction

    // Sample combinational outputs at the falling edge and compare against a beat
    task automatic chk_beat(input string tag, input logic exp_v, input int unsigned exp_tag,
                            input logic [N-1:0] exp_ready);
        @(negedge clk_i);
        check({tag, ".v"}, 64'(fifo_v_o), 64'(exp_v));
        check({tag, ".rdy"}, 64'(ready_o), 64'(exp_ready));
        if (exp_v) begin
            check({tag, ".tag"}, 64'(fifo_data_o[TW+W-1:W]), 64'(exp_tag));
            check({tag, ".data"}, 64'(fifo_data_o[W-1:0]), 64'(slot_data(exp_tag)));
        end
    endtask

    task automatic do_reset();
        reset_i      = 1'b1;
        v_i          = '1;
        last_i       = '1;
        fifo_ready_i = 1'b1;
        deq_v_i      = 1'b0;
        deq_tag_i    = '0;
        tick();
        @(negedge clk_i);
        check("rst.rdy", 64'(ready_o), 64'h0);
        check("rst.v", 64'(fifo_v_o), 64'h0);
        tick();
        reset_i = 1'b0;
        v_i     = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) data_i[i*W +: W] = slot_data(i);

        // 1: all requesting single beats, dequeue the previous beat each cycle
        do_reset();
        for (int k = 0; k < 6; k++) begin
            v_i       = 4'b1111;
            last_i    = 4'b1111;
            deq_v_i   = (k > 0);
            deq_tag_i = TW'((k + 3) % 4);
            chk_beat($sformatf("rr%0d", k), 1'b1, k % 4, 4'(1 << (k % 4)));
            tick();
        end
        v_i       = '0;
        deq_v_i   = 1'b1;
        deq_tag_i = 2'd1;
        chk_beat("rr_idle", 1'b0, 0, 4'b0000);
        tick();
        deq_v_i = 1'b0;

        // 2: quota of two beats per source, one credit releases one more
        do_reset();
        v_i    = 4'b0010;
        last_i = 4'b1111;
        chk_beat("q0", 1'b1, 1, 4'b0010);
        tick();
        chk_beat("q1", 1'b1, 1, 4'b0010);
        tick();
        deq_v_i   = 1'b1;
        deq_tag_i = 2'd1;
        chk_beat("q_full", 1'b0, 0, 4'b0000);
        tick();
        deq_v_i = 1'b0;
        chk_beat("q_credit", 1'b1, 1, 4'b0010);
        tick();
        chk_beat("q_full2", 1'b0, 0, 4'b0000);
        tick();

        // 3: three-beat packet from source 2 holds off source 0
        do_reset();
        v_i    = 4'b0100;
        last_i = 4'b0000;
        chk_beat("pk0", 1'b1, 2, 4'b0100);
        tick();
        v_i       = 4'b0101;
        last_i    = 4'b0001;
        deq_v_i   = 1'b1;
        deq_tag_i = 2'd2;
        chk_beat("pk1", 1'b1, 2, 4'b0100);
        tick();
        last_i = 4'b0101;
        chk_beat("pk2", 1'b1, 2, 4'b0100);
        tick();
        chk_beat("pk_after", 1'b1, 0, 4'b0001);
        tick();
        v_i     = '0;
        deq_v_i = 1'b0;

        // 4: FIFO backpressure holds pointer and counters
        do_reset();
        v_i          = 4'b0101;
        last_i       = 4'b1111;
        fifo_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_beat($sformatf("bp%0d", k), 1'b1, 0, 4'b0000);
            tick();
        end
        fifo_ready_i = 1'b1;
        chk_beat("bp_rel0", 1'b1, 0, 4'b0001);
        tick();
        chk_beat("bp_rel1", 1'b1, 2, 4'b0100);
        tick();
        chk_beat("bp_rel2", 1'b1, 0, 4'b0001);
        tick();
        chk_beat("bp_rel3", 1'b1, 2, 4'b0100);
        tick();
        chk_beat("bp_full", 1'b0, 0, 4'b0000);
        tick();

        // 5: simultaneous inc/dec keeps count; underflow dequeue holds zero
        do_reset();
        v_i    = 4'b1000;
        last_i = 4'b1111;
        chk_beat("sd0", 1'b1, 3, 4'b1000);
        tick();
        deq_v_i   = 1'b1;
        deq_tag_i = 2'd3;
        chk_beat("sd1", 1'b1, 3, 4'b1000);
        tick();
        deq_v_i = 1'b0;
        chk_beat("sd2", 1'b1, 3, 4'b1000);
        tick();
        chk_beat("sd_full", 1'b0, 0, 4'b0000);
        tick();
        v_i       = '0;
        deq_v_i   = 1'b1;
        deq_tag_i = 2'd1;
        tick();
        deq_v_i = 1'b0;
        v_i     = 4'b0010;
        chk_beat("uf0", 1'b1, 1, 4'b0010);
        tick();
        chk_beat("uf1", 1'b1, 1, 4'b0010);
        tick();
        chk_beat("uf_full", 1'b0, 0, 4'b0000);
        tick();

        // 6: asynchronous reset in the middle of a locked packet
        do_reset();
        v_i    = 4'b0010;
        last_i = 4'b0000;
        chk_beat("ar0", 1'b1, 1, 4'b0010);
        tick();
        v_i = 4'b0011;
        chk_beat("ar_lock", 1'b1, 1, 4'b0010);
        #2;
        reset_i = 1'b1;
        #1;
        check("ar.rdy", 64'(ready_o), 64'h0);
        check("ar.v", 64'(fifo_v_o), 64'h0);
        tick();
        reset_i = 1'b0;
        v_i     = 4'b1111;
        last_i  = 4'b1111;
        chk_beat("ar_rr0", 1'b1, 0, 4'b0001);
        tick();
        chk_beat("ar_rr1", 1'b1, 1, 4'b0010);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
